// File: rtl/inst_fetch_loader_if.sv
// Bundle of the fetch-side and loader-side signals of the instruction fetch
// loader. The master drives the PC and the byte stream; the slave (the fetch
// loader itself) drives the fetched instruction and the loader status.
interface inst_fetch_loader_if #(
    parameter int INST_MEM_WIDTH = 10,
    parameter int WORD_BYTES     = 4
);
    localparam int W = 8 * WORD_BYTES;

    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] pc1;
    logic [7:0]                input_data;
    logic                      input_valid;
    logic                      input_start;
    logic                      input_end;

    logic [W-1:0]              inst;
    logic                      inst_enable;
    logic [INST_MEM_WIDTH-1:0] pc_next;
    logic [INST_MEM_WIDTH-1:0] pc1_next;
    logic                      pc_oob;
    logic                      loading;
    logic                      load_error;
    logic [INST_MEM_WIDTH:0]   load_count;
    logic [7:0]                load_checksum;

    modport master (
        output pc, pc1, input_data, input_valid, input_start, input_end,
        input  inst, inst_enable, pc_next, pc1_next, pc_oob,
               loading, load_error, load_count, load_checksum
    );

    modport slave (
        input  pc, pc1, input_data, input_valid, input_start, input_end,
        output inst, inst_enable, pc_next, pc1_next, pc_oob,
               loading, load_error, load_count, load_checksum
    );
endinterface

// File: rtl/inst_fetch_loader.sv
// Instruction fetch stage with an integrated serial program loader.
// Bytes arriving during a load are packed into instruction words and written
// to sequential RAM addresses; the fetch path reads the RAM at pc with one
// cycle of latency and forwards pc/pc1 aligned with the returned instruction.
module inst_fetch_loader #(
    parameter int INST_MEM_WIDTH = 10,
    parameter int WORD_BYTES     = 4,
    parameter bit BIG_ENDIAN     = 1'b1
) (
    input logic               CLK,
    input logic               reset,
    inst_fetch_loader_if.slave bus
);
    localparam int W     = 8 * WORD_BYTES;
    localparam int DEPTH = 1 << INST_MEM_WIDTH;
    localparam int BCW   = $clog2(WORD_BYTES + 1);

    localparam logic [INST_MEM_WIDTH:0] FULL_COUNT = (INST_MEM_WIDTH + 1)'(DEPTH);
    localparam logic [BCW-1:0]          LAST_BYTE  = BCW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {RUN, LOAD, ERR} state_t;

    state_t                    state;
    logic [W-1:0]              mem [0:DEPTH-1];
    logic [W-1:0]              asm_word;
    logic [BCW-1:0]            byte_cnt;
    logic [INST_MEM_WIDTH-1:0] wr_addr;

    logic                      accept;
    logic                      word_done;
    logic                      overflow;
    logic                      mem_we;
    logic [W-1:0]              next_word;
    logic [BCW-1:0]            cnt_after;

    // Decode the current loader byte: acceptance, word completion, overflow
    // and the assembly register value after shifting the byte in.
    always_comb begin
        accept    = (state == LOAD) && !bus.input_start && bus.input_valid;
        word_done = accept && (byte_cnt == LAST_BYTE);
        overflow  = word_done && (bus.load_count == FULL_COUNT);
        mem_we    = word_done && !overflow;
        if (BIG_ENDIAN)
            next_word = (asm_word << 8) | {{(W-8){1'b0}}, bus.input_data};
        else
            next_word = (asm_word >> 8) | {bus.input_data, {(W-8){1'b0}}};
        cnt_after = byte_cnt;
        if (accept)
            cnt_after = word_done ? '0 : byte_cnt + BCW'(1);
    end

    // Instruction RAM write port; contents are deliberately never reset.
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[wr_addr] <= next_word;
    end

    // Fetch path: registered read of the old RAM contents plus pc alignment.
    always_ff @(posedge CLK) begin
        if (reset) begin
            bus.inst     <= '0;
            bus.pc_next  <= '0;
            bus.pc1_next <= '0;
            bus.pc_oob   <= 1'b0;
        end else begin
            bus.inst     <= mem[bus.pc];
            bus.pc_next  <= bus.pc;
            bus.pc1_next <= bus.pc1;
            bus.pc_oob   <= ({1'b0, bus.pc} >= bus.load_count);
        end
    end

    // Loader state machine: start always wins, then overflow, then end check.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state             <= RUN;
            bus.inst_enable   <= 1'b1;
            bus.loading       <= 1'b0;
            bus.load_error    <= 1'b0;
            bus.load_count    <= '0;
            bus.load_checksum <= '0;
            byte_cnt          <= '0;
            wr_addr           <= '0;
            asm_word          <= '0;
        end else if (bus.input_start) begin
            state             <= LOAD;
            bus.inst_enable   <= 1'b0;
            bus.loading       <= 1'b1;
            bus.load_error    <= 1'b0;
            bus.load_count    <= '0;
            bus.load_checksum <= '0;
            byte_cnt          <= '0;
            wr_addr           <= '0;
            asm_word          <= '0;
        end else if (state == LOAD) begin
            if (accept) begin
                asm_word          <= next_word;
                bus.load_checksum <= bus.load_checksum + bus.input_data;
                byte_cnt          <= cnt_after;
            end
            if (mem_we) begin
                wr_addr        <= wr_addr + INST_MEM_WIDTH'(1);
                bus.load_count <= bus.load_count + (INST_MEM_WIDTH + 1)'(1);
            end
            if (overflow) begin
                state          <= ERR;
                bus.loading    <= 1'b0;
                bus.load_error <= 1'b1;
            end else if (bus.input_end) begin
                bus.loading <= 1'b0;
                if (cnt_after == '0) begin
                    state           <= RUN;
                    bus.inst_enable <= 1'b1;
                end else begin
                    state          <= ERR;
                    bus.load_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_loader.sv
// Directed bench for inst_fetch_loader: three instances share one byte
// stream (big-endian, little-endian, and a 4-word RAM for overflow).
module tb_inst_fetch_loader;
    logic        CLK;
    logic        reset;
    logic [9:0]  pc;
    logic [9:0]  pc1;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_start;
    logic        in_end;

    int assert_count;
    int fail_count;

    logic [7:0] prog [8];
    logic [7:0] sum8;

    inst_fetch_loader_if #(.INST_MEM_WIDTH(10), .WORD_BYTES(4)) if_a ();
    inst_fetch_loader_if #(.INST_MEM_WIDTH(10), .WORD_BYTES(4)) if_b ();
    inst_fetch_loader_if #(.INST_MEM_WIDTH(2),  .WORD_BYTES(4)) if_c ();

    assign if_a.pc = pc;       assign if_a.pc1 = pc1;
    assign if_b.pc = pc;       assign if_b.pc1 = pc1;
    assign if_c.pc = pc[1:0];  assign if_c.pc1 = pc1[1:0];
    assign if_a.input_data = in_data;  assign if_a.input_valid = in_valid;
    assign if_a.input_start = in_start; assign if_a.input_end = in_end;
    assign if_b.input_data = in_data;  assign if_b.input_valid = in_valid;
    assign if_b.input_start = in_start; assign if_b.input_end = in_end;
    assign if_c.input_data = in_data;  assign if_c.input_valid = in_valid;
    assign if_c.input_start = in_start; assign if_c.input_end = in_end;

    inst_fetch_loader #(.INST_MEM_WIDTH(10), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut_a (
        .CLK(CLK), .reset(reset), .bus(if_a.slave));
    inst_fetch_loader #(.INST_MEM_WIDTH(10), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut_b (
        .CLK(CLK), .reset(reset), .bus(if_b.slave));
    inst_fetch_loader #(.INST_MEM_WIDTH(2), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut_c (
        .CLK(CLK), .reset(reset), .bus(if_c.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic s, input logic e, input logic v, input logic [7:0] d);
        in_start = s;
        in_end   = e;
        in_valid = v;
        in_data  = d;
        @(negedge CLK);
        in_start = 1'b0;
        in_end   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        sum8 = 8'h00;
        for (int i = 0; i < 8; i++) sum8 = sum8 + prog[i];
        reset = 1'b1; pc = '0; pc1 = '0;
        in_data = '0; in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // reset values
        checkOutput("rst_inst_enable", 64'(if_a.inst_enable), 64'd1);
        checkOutput("rst_loading",     64'(if_a.loading),     64'd0);
        checkOutput("rst_load_error",  64'(if_a.load_error),  64'd0);
        checkOutput("rst_load_count",  64'(if_a.load_count),  64'd0);
        checkOutput("rst_checksum",    64'(if_a.load_checksum), 64'd0);
        checkOutput("rst_inst",        64'(if_a.inst),        64'd0);
        checkOutput("rst_pc_oob",      64'(if_a.pc_oob),      64'd0);
        reset = 1'b0;
        @(negedge CLK);

        // start and end together in RUN: start wins
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("se_loading",     64'(if_a.loading),     64'd1);
        checkOutput("se_inst_enable", 64'(if_a.inst_enable), 64'd0);

        // eight bytes, the last one together with end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, (i == 7), 1'b1, prog[i]);
        checkOutput("ld_loading",     64'(if_a.loading),       64'd0);
        checkOutput("ld_inst_enable", 64'(if_a.inst_enable),   64'd1);
        checkOutput("ld_load_count",  64'(if_a.load_count),    64'd2);
        checkOutput("ld_checksum",    64'(if_a.load_checksum), 64'(sum8));
        checkOutput("ld_checksum_c",  64'(if_a.load_checksum), 64'h38);
        checkOutput("ld_load_error",  64'(if_a.load_error),    64'd0);

        // fetch both words, both endianness variants
        pc = 10'd0; pc1 = 10'd1;
        @(negedge CLK);
        checkOutput("be_mem0", 64'(if_a.inst), 64'h12345678);
        checkOutput("le_mem0", 64'(if_b.inst), 64'h78563412);
        pc = 10'd1; pc1 = 10'd2;
        @(negedge CLK);
        checkOutput("be_mem1",   64'(if_a.inst),     64'h9ABCDEF0);
        checkOutput("le_mem1",   64'(if_b.inst),     64'hF0DEBC9A);
        checkOutput("pc_next",   64'(if_a.pc_next),  64'd1);
        checkOutput("pc1_next",  64'(if_a.pc1_next), 64'd2);
        checkOutput("oob_in",    64'(if_a.pc_oob),   64'd0);
        pc = 10'd2;
        @(negedge CLK);
        checkOutput("oob_edge",  64'(if_a.pc_oob),   64'd1);

        // framing error: five bytes then end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h11 * (i + 1)));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fr_load_error",  64'(if_a.load_error),  64'd1);
        checkOutput("fr_inst_enable", 64'(if_a.inst_enable), 64'd0);
        checkOutput("fr_load_count",  64'(if_a.load_count),  64'd1);
        checkOutput("fr_loading",     64'(if_a.loading),     64'd0);

        // recovery: start, four bytes, end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rc_err_clear", 64'(if_a.load_error), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'hA1 + i));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rc_load_error",  64'(if_a.load_error),  64'd0);
        checkOutput("rc_inst_enable", 64'(if_a.inst_enable), 64'd1);
        checkOutput("rc_load_count",  64'(if_a.load_count),  64'd1);

        // five words into the 4-word instance
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
        checkOutput("ov_before", 64'(if_c.load_error), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h53);
        checkOutput("ov_error",     64'(if_c.load_error),  64'd1);
        checkOutput("ov_count",     64'(if_c.load_count),  64'd4);
        checkOutput("ov_loading",   64'(if_c.loading),     64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("ov_enable",    64'(if_c.inst_enable), 64'd0);
        checkOutput("ov_a_enable",  64'(if_a.inst_enable), 64'd1);
        checkOutput("ov_a_count",   64'(if_a.load_count),  64'd5);
        pc = 10'd0;
        @(negedge CLK);
        checkOutput("ov_mem0", 64'(if_c.inst), 64'h40414243);
        pc = 10'd3;
        @(negedge CLK);
        checkOutput("ov_mem3", 64'(if_c.inst), 64'h4C4D4E4F);
        pc = 10'd4;
        @(negedge CLK);
        checkOutput("a_mem4",   64'(if_a.inst),   64'h50515253);
        checkOutput("a_oob4",   64'(if_a.pc_oob), 64'd0);
        pc = 10'd5;
        @(negedge CLK);
        checkOutput("a_oob5",   64'(if_a.pc_oob), 64'd1);

        // reset in the middle of a load
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h77 + i));
        checkOutput("mid_loading", 64'(if_a.loading), 64'd1);
        pc = 10'd0;
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        checkOutput("mr_loading",     64'(if_a.loading),     64'd0);
        checkOutput("mr_inst_enable", 64'(if_a.inst_enable), 64'd1);
        checkOutput("mr_load_count",  64'(if_a.load_count),  64'd0);
        checkOutput("mr_checksum",    64'(if_a.load_checksum), 64'd0);
        @(negedge CLK);
        checkOutput("mr_oob0",  64'(if_a.pc_oob), 64'd1);
        checkOutput("mr_keep0", 64'(if_a.inst),   64'h40414243);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
